// File: rtl/hdr_merge_stream_pkg.sv
// Shared constants, framing state type and weight clamp helper for the HDR merge stage.
// Optional feature macro used by this block: HDR_SATURATION_FLAG_EN.
package hdr_pkg;

  localparam int HDR_LAT  = 3;
  localparam int HDR_FRAC = 2;

  typedef enum logic {
    IDLE,
    IN_FRAME
  } state_t;

  // Limits a programmed weight to the full-scale value 2^ww.
  function automatic int unsigned weight_clamp(input int unsigned w, input int unsigned ww);
    int unsigned full;
    full = 32'd1 << ww;
    return (w > full) ? full : w;
  endfunction

endpackage

// File: rtl/hdr_merge_stream_if.sv
// Avalon-ST sink (two exposures) and blended source bundle of the HDR merge stage.
// Optional feature macro used by this block: HDR_SATURATION_FLAG_EN.
interface hdr_merge_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_NUM     = 3
);
  import hdr_pkg::*;

  logic                                      asi_snk_valid;
  logic                                      asi_snk_startofpacket;
  logic                                      asi_snk_endofpacket;
  logic [CH_NUM*DATA_WIDTH-1:0]              asi_snk_0_data;
  logic [CH_NUM*DATA_WIDTH-1:0]              asi_snk_1_data;
  logic                                      aso_src_valid;
  logic                                      aso_src_startofpacket;
  logic                                      aso_src_endofpacket;
  logic [CH_NUM*(DATA_WIDTH+HDR_FRAC)-1:0]   aso_src_data;

  modport master (
    output asi_snk_valid, asi_snk_startofpacket, asi_snk_endofpacket,
    output asi_snk_0_data, asi_snk_1_data,
    input  aso_src_valid, aso_src_startofpacket, aso_src_endofpacket, aso_src_data
  );

  modport slave (
    input  asi_snk_valid, asi_snk_startofpacket, asi_snk_endofpacket,
    input  asi_snk_0_data, asi_snk_1_data,
    output aso_src_valid, aso_src_startofpacket, aso_src_endofpacket, aso_src_data
  );

endinterface

// File: rtl/hdr_merge_stream_blend_lane.sv
// One colour lane of the exposure blend: multiply, add, then shift to 2 fractional bits.
// Optional feature macro used by this block: HDR_SATURATION_FLAG_EN (handled by the caller).
module hdr_blend_lane
  import hdr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WW         = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WW:0]                    w,
  input  logic [DATA_WIDTH-1:0]          d0,
  input  logic [DATA_WIDTH-1:0]          d1,
  output logic [DATA_WIDTH+HDR_FRAC-1:0] res
);

  localparam int          PW   = DATA_WIDTH + WW;
  localparam logic [WW:0] FULL = {1'b1, {WW{1'b0}}};

  logic [PW-1:0] prod0_q;
  logic [PW-1:0] prod1_q;
  logic [PW-1:0] sum_q;

  // w never exceeds FULL, so FULL - w cannot wrap and the sum stays below 2^PW.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod0_q <= '0;
      prod1_q <= '0;
      sum_q   <= '0;
      res     <= '0;
    end else begin
      prod0_q <= PW'(w) * PW'(d0);
      prod1_q <= PW'(FULL - w) * PW'(d1);
      sum_q   <= prod0_q + prod1_q;
      res     <= (DATA_WIDTH+HDR_FRAC)'(sum_q >> (WW - HDR_FRAC));
    end
  end

endmodule

// File: rtl/hdr_merge_stream.sv
// HDR exposure-fusion stage: framing FSM, frame-coherent weight latch, sideband delay and lanes.
// Optional feature macro: HDR_SATURATION_FLAG_EN (per-lane saturation override and sat_seen_o).
module hdr_merge_stream
  import hdr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CH_NUM     = 3,
  parameter int WW         = 4,
  parameter int CNT_W      = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WW:0]       cfg_weight_i,
  hdr_merge_stream_if.slave st,
  output logic              frame_done_o,
  output logic [CNT_W-1:0]  frame_len_o,
  output logic              frame_err_o
`ifdef HDR_SATURATION_FLAG_EN
  ,
  output logic              sat_seen_o
`endif
);

  localparam int OW = DATA_WIDTH + HDR_FRAC;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc, len_d;
  logic [WW:0]      weight_q, weight_d;
  logic             sop_acc, fwd, done_d, err_d;

  logic [HDR_LAT-1:0] vld_sr, sop_sr, eop_sr, done_sr, err_sr;
  logic [CNT_W-1:0]   len_sr [HDR_LAT-1];
  logic [OW-1:0]      lane_res [CH_NUM];

  assign sop_acc   = st.asi_snk_valid && st.asi_snk_startofpacket;
  assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;

  // An accepted SOP uses the freshly clamped weight on its own beat.
  always_comb begin
    weight_d = weight_q;
    if (sop_acc) begin
      weight_d = (WW+1)'(weight_clamp(32'(cfg_weight_i), WW));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = '0;
    fwd     = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (st.asi_snk_valid) begin
      unique case (state_q)
        IDLE: begin
          if (st.asi_snk_startofpacket) begin
            fwd = 1'b1;
            if (st.asi_snk_endofpacket) begin
              done_d = 1'b1;
              len_d  = CNT_W'(1);
            end else begin
              state_d = IN_FRAME;
              count_d = CNT_W'(1);
            end
          end else begin
            err_d = 1'b1;
          end
        end
        IN_FRAME: begin
          fwd = 1'b1;
          if (st.asi_snk_startofpacket) begin
            err_d = 1'b1;
            if (st.asi_snk_endofpacket) begin
              done_d  = 1'b1;
              len_d   = CNT_W'(1);
              state_d = IDLE;
            end else begin
              count_d = CNT_W'(1);
            end
          end else if (st.asi_snk_endofpacket) begin
            done_d  = 1'b1;
            len_d   = count_inc;
            state_d = IDLE;
          end else begin
            count_d = count_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      weight_q <= '0;
    end else begin
      count_q  <= count_d;
      weight_q <= weight_d;
    end
  end

  // Sideband shift registers match the three-stage lane pipeline beat for beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr      <= '0;
      sop_sr      <= '0;
      eop_sr      <= '0;
      done_sr     <= '0;
      err_sr      <= '0;
      frame_len_o <= '0;
      for (int i = 0; i < HDR_LAT-1; i++) begin
        len_sr[i] <= '0;
      end
    end else begin
      vld_sr  <= {vld_sr[HDR_LAT-2:0], fwd};
      sop_sr  <= {sop_sr[HDR_LAT-2:0], fwd && st.asi_snk_startofpacket};
      eop_sr  <= {eop_sr[HDR_LAT-2:0], fwd && st.asi_snk_endofpacket};
      done_sr <= {done_sr[HDR_LAT-2:0], done_d};
      err_sr  <= {err_sr[HDR_LAT-2:0], err_d};
      len_sr[0] <= len_d;
      for (int i = 1; i < HDR_LAT-1; i++) begin
        len_sr[i] <= len_sr[i-1];
      end
      if (done_sr[HDR_LAT-2]) begin
        frame_len_o <= len_sr[HDR_LAT-2];
      end
    end
  end

  assign st.aso_src_valid         = vld_sr[HDR_LAT-1];
  assign st.aso_src_startofpacket = sop_sr[HDR_LAT-1];
  assign st.aso_src_endofpacket   = eop_sr[HDR_LAT-1];
  assign frame_done_o             = done_sr[HDR_LAT-1];
  assign frame_err_o              = err_sr[HDR_LAT-1];

`ifdef HDR_SATURATION_FLAG_EN
  logic [CH_NUM-1:0] lane_sat;
  logic              sat_q;
`endif

  for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] d0_lane;
    logic [WW:0]           lane_w;

    assign d0_lane = st.asi_snk_0_data[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef HDR_SATURATION_FLAG_EN
    assign lane_sat[k] = &d0_lane;
    assign lane_w      = lane_sat[k] ? '0 : weight_d;
`else
    assign lane_w = weight_d;
`endif

    hdr_blend_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .WW        (WW)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .w  (lane_w),
      .d0 (d0_lane),
      .d1 (st.asi_snk_1_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .res(lane_res[k])
    );
  end

  always_comb begin
    st.aso_src_data = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      st.aso_src_data[k*OW +: OW] = lane_res[k];
    end
  end

`ifdef HDR_SATURATION_FLAG_EN
  // Sticky per frame: an accepted SOP restarts it from that beat's own saturation state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (sop_acc) begin
      sat_q <= |lane_sat;
    end else if (fwd && (|lane_sat)) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_seen_o = sat_q;
`endif

endmodule

// File: tb/tb_hdr_merge_stream.sv
// Scoreboard bench for hdr_merge_stream: a frame-level reference model queues expected beats.
// Optional feature macro honoured: HDR_SATURATION_FLAG_EN.
module tb_hdr_merge_stream;
  import hdr_pkg::*;

  localparam int DW      = 8;
  localparam int CH      = 3;
  localparam int WW      = 4;
  localparam int CNT_W   = 22;
  localparam int OW      = DW + 2;
  localparam int FULL_W  = 1 << WW;
  localparam int DIV     = 1 << (WW - 2);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    int                 cyc;
    logic [CH*OW-1:0]   data;
    bit                 sop;
    bit                 eop;
    bit                 done;
    int                 len;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WW:0]      cfg_weight = '0;
  logic             frame_done;
  logic             frame_err;
  logic [CNT_W-1:0] frame_len;
`ifdef HDR_SATURATION_FLAG_EN
  logic             sat_seen;
`endif

  hdr_merge_stream_if #(.DATA_WIDTH(DW), .CH_NUM(CH)) st ();

  hdr_merge_stream #(
    .DATA_WIDTH(DW),
    .CH_NUM    (CH),
    .WW        (WW),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_weight_i(cfg_weight),
    .st          (st.slave),
    .frame_done_o(frame_done),
    .frame_len_o (frame_len),
    .frame_err_o (frame_err)
`ifdef HDR_SATURATION_FLAG_EN
    ,
    .sat_seen_o  (sat_seen)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t beat_q[$];
  int    err_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;
  int    mon_len = 0;

  bit    m_in_frame = 1'b0;
  int    m_count = 0;
  int    m_weight = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one input cycle and records what the frame rules say must come out HDR_LAT later.
  task automatic applyStimulus(input bit v, input bit s, input bit e, input logic [WW:0] w,
                               input logic [CH*DW-1:0] d0, input logic [CH*DW-1:0] d1);
    beat_t b;
    st.asi_snk_valid         = v;
    st.asi_snk_startofpacket = s;
    st.asi_snk_endofpacket   = e;
    st.asi_snk_0_data        = d0;
    st.asi_snk_1_data        = d1;
    cfg_weight               = w;
    if (v) begin
      if (s) m_weight = (int'(w) > FULL_W) ? FULL_W : int'(w);
      if (!m_in_frame && !s) begin
        err_q.push_back(cyc + HDR_LAT);
      end else begin
        b.cyc  = cyc + HDR_LAT;
        b.sop  = s;
        b.eop  = e;
        b.done = 1'b0;
        b.len  = 0;
        b.data = '0;
        for (int k = 0; k < CH; k++) begin
          int a, c, wl;
          a  = int'(d0[k*DW +: DW]);
          c  = int'(d1[k*DW +: DW]);
          wl = m_weight;
`ifdef HDR_SATURATION_FLAG_EN
          if (a == (1 << DW) - 1) wl = 0;
`endif
          b.data[k*OW +: OW] = OW'((wl * a + (FULL_W - wl) * c) / DIV);
        end
        if (s) begin
          if (m_in_frame) err_q.push_back(cyc + HDR_LAT);
          m_count    = 1;
          m_in_frame = !e;
          if (e) begin
            b.done = 1'b1;
            b.len  = 1;
          end
        end else if (e) begin
          b.done     = 1'b1;
          b.len      = (m_count + 1 > CNT_MAX) ? CNT_MAX : m_count + 1;
          m_in_frame = 1'b0;
        end else begin
          m_count = (m_count + 1 > CNT_MAX) ? CNT_MAX : m_count + 1;
        end
        beat_q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset: anything still due after the reset edge is lost, as is the model state.
  task automatic doReset();
    int n;
    n = cyc;
    rst = 1'b1;
    st.asi_snk_valid = 1'b0;
    while (beat_q.size() > 0 && beat_q[$].cyc >= n + 1) void'(beat_q.pop_back());
    while (err_q.size() > 0 && err_q[$] >= n + 1) void'(err_q.pop_back());
    m_in_frame = 1'b0;
    m_count    = 0;
    m_weight   = 0;
    @(posedge clk);
    mon_en = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", st.aso_src_valid, 0);
    checkOutput("rst_sideband", {st.aso_src_startofpacket, st.aso_src_endofpacket, frame_done, frame_err}, 0);
    checkOutput("rst_data", st.aso_src_data, 0);
    checkOutput("rst_frame_len", frame_len, 0);
    mon_len = 0;
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (st.aso_src_valid) begin
        checkOutput("beat_pending", beat_q.size() != 0, 1);
        if (beat_q.size() != 0) begin
          beat_t e;
          e = beat_q.pop_front();
          checkOutput("beat_cycle", cyc, e.cyc);
          checkOutput("data", st.aso_src_data, e.data);
          checkOutput("sop_eop_done", {st.aso_src_startofpacket, st.aso_src_endofpacket, frame_done},
                      {e.sop, e.eop, e.done});
          if (e.done) mon_len = e.len;
        end
      end else begin
        checkOutput("idle_sideband", {st.aso_src_startofpacket, st.aso_src_endofpacket, frame_done}, 0);
      end
      checkOutput("frame_len", frame_len, mon_len);
      if (frame_err) begin
        checkOutput("err_pending", err_q.size() != 0, 1);
        if (err_q.size() != 0) checkOutput("err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  initial begin
    logic [CH*DW-1:0] a200, b100, rd0, rd1;
    a200 = {CH{8'd200}};
    b100 = {CH{8'd100}};
    st.asi_snk_valid = 1'b0;
    st.asi_snk_startofpacket = 1'b0;
    st.asi_snk_endofpacket = 1'b0;
    st.asi_snk_0_data = '0;
    st.asi_snk_1_data = '0;
    @(posedge clk);
    #1;
    doReset();

    // Single-pixel frames at several weights, including an over-range one.
    applyStimulus(1, 1, 1, 5'd8,  a200, b100);
    applyStimulus(1, 1, 1, 5'd16, a200, b100);
    applyStimulus(1, 1, 1, 5'd0,  a200, b100);
    applyStimulus(1, 1, 1, 5'd31, a200, b100);
    applyStimulus(0, 0, 0, 5'd3,  a200, b100);

    // Five-beat frame with cfg_weight_i changing mid-frame.
    applyStimulus(1, 1, 0, 5'd8,  a200, b100);
    applyStimulus(1, 0, 0, 5'd3,  a200, b100);
    applyStimulus(1, 0, 0, 5'd12, a200, b100);
    applyStimulus(1, 0, 0, 5'd0,  a200, b100);
    applyStimulus(1, 0, 1, 5'd16, a200, b100);

    // Stray beat in IDLE, then a single-pixel frame.
    applyStimulus(1, 0, 0, 5'd5, a200, b100);
    applyStimulus(1, 1, 1, 5'd5, a200, b100);

    // SOP inside an open frame restarts it.
    for (int i = 0; i < 5; i++) begin
      rd0 = (CH*DW)'($urandom);
      rd1 = (CH*DW)'($urandom);
      applyStimulus(1, (i == 0) || (i == 2), i == 4, 5'($urandom_range(0, 31)), rd0, rd1);
    end

    // Reset with two beats in flight, then an orphan EOP.
    for (int i = 0; i < 3; i++) begin
      rd0 = (CH*DW)'($urandom);
      rd1 = (CH*DW)'($urandom);
      applyStimulus(1, i == 0, 0, 5'($urandom_range(0, 31)), rd0, rd1);
    end
    doReset();
    applyStimulus(1, 0, 1, 5'd9, a200, b100);
    applyStimulus(0, 0, 0, 5'd9, a200, b100);

    // Randomised frames with bubbles, stray beats and mid-frame restarts.
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        bit s;
        s = (b == 0) || ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 4) == 0) begin
          applyStimulus(0, 1'($urandom), 1'($urandom), 5'($urandom), (CH*DW)'($urandom), (CH*DW)'($urandom));
        end
        applyStimulus(1, s, b == len - 1, 5'($urandom_range(0, 31)), (CH*DW)'($urandom), (CH*DW)'($urandom));
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        applyStimulus(0, 1'($urandom), 1'($urandom), 5'($urandom), (CH*DW)'($urandom), (CH*DW)'($urandom));
      end
      if ($urandom_range(0, 7) == 0) begin
        applyStimulus(1, 0, 1'($urandom), 5'($urandom), (CH*DW)'($urandom), (CH*DW)'($urandom));
      end
    end

    for (int i = 0; i < HDR_LAT + 3; i++) begin
      applyStimulus(0, 0, 0, 5'd0, '0, '0);
    end
    checkOutput("beats_left", beat_q.size(), 0);
    checkOutput("errs_left", err_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
